// File: rtl/mem_stage.sv
// mem_stage: load/store unit between register read and writeback, driving a word-wide single-port data RAM.
// Byte stores are read-modify-write; byte order is big-endian (offset 0 = bits [31:24]).
// Build option MEM_STAGE_UNALIGNED_TRAP_EN: misaligned word accesses trap (done+fault) instead of being aligned.
module mem_stage #(
    parameter int FULLW   = 32,
    parameter int REGAW   = 4,
    parameter int MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic             req_byte,
    input  logic [FULLW-1:0] req_addr,
    input  logic [FULLW-1:0] req_wdata,
    input  logic [REGAW-1:0] req_rd,
    output logic             mem_en,
    output logic             mem_we,
    output logic [FULLW-1:0] mem_ad,
    output logic [FULLW-1:0] mem_d,
    input  logic [FULLW-1:0] mem_q,
    output logic             wb_valid,
    output logic [REGAW-1:0] wb_rd,
    output logic [FULLW-1:0] wb_data,
    output logic             done,
    output logic             fault
);
    typedef enum logic [2:0] {IDLE, RD_WAIT, MERGE, WRITE, RESP} state_t;

    localparam logic [FULLW-1:0] BMASK = FULLW'(8'hFF);

    state_t           state;
    logic [1:0]       cnt;
    logic [1:0]       lane;
    logic             we_l;
    logic             byte_l;
    logic [7:0]       wbyte;
    logic [REGAW-1:0] rd_l;
    logic [FULLW-1:0] rbuf;
    logic [4:0]       sh;
    logic [FULLW-1:0] rd_byte;
    logic [FULLW-1:0] merged;
    logic             trap;

`ifdef MEM_STAGE_UNALIGNED_TRAP_EN
    assign trap = ~req_byte & (req_addr[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif

    assign req_ready = (state == IDLE);
    // big-endian lane: offset 0 sits in the top byte, so shift = (3 - offset) * 8
    assign sh        = {~lane, 3'b000};
    assign rd_byte   = (mem_q >> sh) & BMASK;
    assign merged    = (rbuf & ~(BMASK << sh)) | (FULLW'(wbyte) << sh);

    // transaction FSM; every RAM strobe and handshake output is a registered one-cycle pulse
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= IDLE;
            cnt      <= '0;
            lane     <= '0;
            we_l     <= 1'b0;
            byte_l   <= 1'b0;
            wbyte    <= '0;
            rd_l     <= '0;
            rbuf     <= '0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_ad   <= '0;
            mem_d    <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            done     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            wb_valid <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    we_l   <= req_we;
                    byte_l <= req_byte;
                    lane   <= req_addr[1:0];
                    wbyte  <= req_wdata[7:0];
                    rd_l   <= req_rd;
                    if (trap) begin
                        done  <= 1'b1;
                        fault <= 1'b1;
                        state <= RESP;
                    end else begin
                        mem_en <= 1'b1;
                        mem_we <= req_we & ~req_byte;
                        mem_ad <= {req_addr[FULLW-1:2], 2'b00};
                        if (req_we & ~req_byte) begin
                            mem_d <= req_wdata;
                            state <= WRITE;
                        end else begin
                            cnt   <= 2'(MEM_LAT - 1);
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: if (cnt != 2'd0) begin
                    cnt <= cnt - 2'd1;
                end else if (we_l) begin
                    rbuf  <= mem_q;
                    state <= MERGE;
                end else begin
                    wb_valid <= 1'b1;
                    done     <= 1'b1;
                    wb_rd    <= rd_l;
                    wb_data  <= byte_l ? rd_byte : mem_q;
                    state    <= RESP;
                end
                MERGE: begin
                    mem_en <= 1'b1;
                    mem_we <= 1'b1;
                    mem_d  <= merged;
                    state  <= WRITE;
                end
                WRITE: begin
                    done  <= 1'b1;
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage with MEM_LAT=1 (dut_a) and MEM_LAT=3 (dut_b) against behavioural RAMs.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic        we = 1'b0, byt = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  rd = '0;
    logic        ready_a, en_a, mwe_a, wbv_a, done_a, fault_a;
    logic        ready_b, en_b, mwe_b, wbv_b, done_b, fault_b;
    logic [31:0] ad_a, d_a, q_a, wbd_a, ad_b, d_b, q_b, wbd_b;
    logic [3:0]  wbrd_a, wbrd_b;
    logic        pw = 1'b0;
    logic [5:0]  pa = '0;
    logic [31:0] pd = '0;
    logic [31:0] ram_a [64];
    logic [31:0] ram_b [64];
    logic [31:0] qb1, qb2;
    int          checks = 0, failures = 0;
    int          web_cnt = 0, wbvb_cnt = 0;

    always #5 clk = ~clk;

    mem_stage #(.FULLW(32), .REGAW(4), .MEM_LAT(1)) dut_a (
        .clk(clk), .nreset(nreset), .req_valid(valid_a), .req_ready(ready_a),
        .req_we(we), .req_byte(byt), .req_addr(addr), .req_wdata(wdata), .req_rd(rd),
        .mem_en(en_a), .mem_we(mwe_a), .mem_ad(ad_a), .mem_d(d_a), .mem_q(q_a),
        .wb_valid(wbv_a), .wb_rd(wbrd_a), .wb_data(wbd_a), .done(done_a), .fault(fault_a)
    );

    mem_stage #(.FULLW(32), .REGAW(4), .MEM_LAT(3)) dut_b (
        .clk(clk), .nreset(nreset), .req_valid(valid_b), .req_ready(ready_b),
        .req_we(we), .req_byte(byt), .req_addr(addr), .req_wdata(wdata), .req_rd(rd),
        .mem_en(en_b), .mem_we(mwe_b), .mem_ad(ad_b), .mem_d(d_b), .mem_q(q_b),
        .wb_valid(wbv_b), .wb_rd(wbrd_b), .wb_data(wbd_b), .done(done_b), .fault(fault_b)
    );

    always @(posedge clk) begin
        if (pw) begin
            ram_a[pa] <= pd;
            ram_b[pa] <= pd;
        end else begin
            if (en_a && mwe_a) ram_a[ad_a[7:2]] <= d_a;
            if (en_b && mwe_b) ram_b[ad_b[7:2]] <= d_b;
        end
        qb1 <= ram_b[ad_b[7:2]];
        qb2 <= qb1;
        if (en_b && mwe_b) web_cnt <= web_cnt + 1;
        if (wbv_b) wbvb_cnt <= wbvb_cnt + 1;
    end
    assign q_a = ram_a[ad_a[7:2]];
    assign q_b = qb2;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d, input logic [3:0] r);
        we = w; byt = b; addr = a; wdata = d; rd = r;
        valid_a = 1'b1;
        step;
        valid_a = 1'b0;
    endtask

    initial begin
        pw = 1'b1; pa = 6'd4; pd = 32'hDEADBEEF;
        step;
        pw = 1'b0;
        chk("rst_en", {31'b0, en_a}, 0);
        chk("rst_we", {31'b0, mwe_a}, 0);
        chk("rst_wbv", {31'b0, wbv_a}, 0);
        chk("rst_done", {31'b0, done_a}, 0);
        chk("rst_fault", {31'b0, fault_a}, 0);
        chk("rst_ad", ad_a, 0);
        chk("rst_wbdata", wbd_a, 0);
        step;
        nreset = 1'b1;
        step;
        chk("ready_init", {31'b0, ready_a}, 1);

        // word load 0x10 -> r3
        issue(1'b0, 1'b0, 32'h10, 32'h0, 4'd3);
        chk("wl_en", {31'b0, en_a}, 1);
        chk("wl_we", {31'b0, mwe_a}, 0);
        chk("wl_ad", ad_a, 32'h10);
        chk("wl_busy", {31'b0, ready_a}, 0);
        step;
        chk("wl_wbv", {31'b0, wbv_a}, 1);
        chk("wl_rd", {28'b0, wbrd_a}, 3);
        chk("wl_data", wbd_a, 32'hDEADBEEF);
        chk("wl_done", {31'b0, done_a}, 1);
        chk("wl_en_off", {31'b0, en_a}, 0);
        step;
        chk("wl_ready", {31'b0, ready_a}, 1);
        chk("wl_wbv_off", {31'b0, wbv_a}, 0);

        // byte loads from the same word, r15 passes through untouched
        issue(1'b0, 1'b1, 32'h11, 32'h0, 4'd15);
        step;
        chk("bl1_data", wbd_a, 32'h000000AD);
        chk("bl1_rd", {28'b0, wbrd_a}, 15);
        step;
        issue(1'b0, 1'b1, 32'h13, 32'h0, 4'd5);
        step;
        chk("bl3_data", wbd_a, 32'h000000EF);
        step;
        issue(1'b0, 1'b1, 32'h10, 32'h0, 4'd5);
        step;
        chk("bl0_data", wbd_a, 32'h000000DE);
        step;

        // byte store 0x5A to 0x12 (upper wdata bits must be ignored)
        issue(1'b1, 1'b1, 32'h12, 32'hFFFFFF5A, 4'd0);
        chk("bs_rd_en", {31'b0, en_a}, 1);
        chk("bs_rd_we", {31'b0, mwe_a}, 0);
        step;
        chk("bs_merge_en", {31'b0, en_a}, 0);
        chk("bs_merge_done", {31'b0, done_a}, 0);
        step;
        chk("bs_wr_en", {31'b0, en_a}, 1);
        chk("bs_wr_we", {31'b0, mwe_a}, 1);
        chk("bs_wr_d", d_a, 32'hDEAD5AEF);
        chk("bs_wr_ad", ad_a, 32'h10);
        step;
        chk("bs_done", {31'b0, done_a}, 1);
        chk("bs_no_wbv", {31'b0, wbv_a}, 0);
        chk("bs_we_off", {31'b0, mwe_a}, 0);
        chk("bs_ram", ram_a[4], 32'hDEAD5AEF);
        step;
        chk("bs_ready", {31'b0, ready_a}, 1);
        issue(1'b0, 1'b0, 32'h10, 32'h0, 4'd1);
        step;
        chk("bs_readback", wbd_a, 32'hDEAD5AEF);
        step;

        // word store with req_valid held high throughout
        we = 1'b1; byt = 1'b0; addr = 32'h20; wdata = 32'h12345678; rd = 4'd0;
        valid_a = 1'b1;
        step;
        chk("ws_en", {31'b0, en_a}, 1);
        chk("ws_we", {31'b0, mwe_a}, 1);
        chk("ws_ad", ad_a, 32'h20);
        chk("ws_d", d_a, 32'h12345678);
        step;
        chk("ws_done", {31'b0, done_a}, 1);
        chk("ws_busy_en", {31'b0, en_a}, 0);
        chk("ws_busy", {31'b0, ready_a}, 0);
        step;
        chk("ws_idle_noacc", {31'b0, en_a}, 0);
        chk("ws_idle_ready", {31'b0, ready_a}, 1);
        step;
        valid_a = 1'b0;
        chk("ws_reaccept", {31'b0, en_a}, 1);
        step;
        step;
        chk("ws_ram", ram_a[8], 32'h12345678);

        // misaligned word load from 0x22
        issue(1'b0, 1'b0, 32'h22, 32'h0, 4'd7);
`ifdef MEM_STAGE_UNALIGNED_TRAP_EN
        chk("ua_done", {31'b0, done_a}, 1);
        chk("ua_fault", {31'b0, fault_a}, 1);
        chk("ua_no_en", {31'b0, en_a}, 0);
        chk("ua_no_wbv", {31'b0, wbv_a}, 0);
        step;
        chk("ua_ready", {31'b0, ready_a}, 1);
        chk("ua_done_off", {31'b0, done_a}, 0);
`else
        chk("ua_en", {31'b0, en_a}, 1);
        chk("ua_ad", ad_a, 32'h20);
        step;
        chk("ua_wbv", {31'b0, wbv_a}, 1);
        chk("ua_data", wbd_a, 32'h12345678);
        chk("ua_fault", {31'b0, fault_a}, 0);
        step;
        chk("ua_ready", {31'b0, ready_a}, 1);
`endif

        // reset during RD_WAIT of a byte-store RMW on the MEM_LAT=3 unit
        we = 1'b1; byt = 1'b1; addr = 32'h12; wdata = 32'h5A; rd = 4'd0;
        valid_b = 1'b1;
        step;
        valid_b = 1'b0;
        chk("rr_en", {31'b0, en_b}, 1);
        chk("rr_we", {31'b0, mwe_b}, 0);
        step;
        chk("rr_wait_busy", {31'b0, ready_b}, 0);
        nreset = 1'b0;
        #1;
        chk("rr_en0", {31'b0, en_b}, 0);
        chk("rr_ad0", ad_b, 0);
        chk("rr_d0", d_b, 0);
        chk("rr_done0", {31'b0, done_b}, 0);
        step;
        step;
        nreset = 1'b1;
        step;
        chk("rr_ready", {31'b0, ready_b}, 1);
        repeat (6) step;
        chk("rr_no_we", web_cnt, 0);
        chk("rr_no_wbv", wbvb_cnt, 0);
        chk("rr_ram", ram_b[4], 32'hDEADBEEF);
        chk("rr_idle_done", {31'b0, done_b}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
